// File: rtl/dsm_pkg.sv
// rtl/dsm_pkg.sv - shared constants and helpers for the parametrised MASH modulator
package dsm_pkg;

  localparam logic [2:0] ORD_1 = 3'd1;
  localparam logic [2:0] ORD_2 = 3'd2;
  localparam logic [2:0] ORD_3 = 3'd3;
  localparam logic [2:0] ORD_4 = 3'd4;

  // Output warm-up tracker: two enabled edges before the first live sample.
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WARM,
    ST_LIVE
  } warm_state_e;

  // A request of 0 or above the built maximum falls back to the maximum order.
  function automatic logic [2:0] clamp_order(input logic [2:0] ord, input int max_order);
    if (ord < ORD_1 || int'(ord) > max_order) return 3'(max_order);
    return ord;
  endfunction

  // Second tap exponent t of the LFSR polynomial x^w + x^t + 1.
  function automatic int lfsr_tap(input int w);
    case (w)
      7:       return 6;
      9:       return 5;
      15:      return 14;
      17:      return 14;
      23:      return 18;
      31:      return 28;
      default: return 18;
    endcase
  endfunction

  // Narrowest signed width holding -(2^(m-1)-1) .. 2^(m-1).
  function automatic int out_w_min(input int max_order);
    return max_order + 1;
  endfunction

endpackage

// File: rtl/mash_accum.sv
// rtl/mash_accum.sv - one MASH stage: modulo accumulator with carry-out
module mash_accum #(
  parameter int ACC_W = 24
) (
  input  logic             Clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             clear,
  input  logic [ACC_W-1:0] in_data,
  input  logic             cin,
  output logic [ACC_W-1:0] acc,
  output logic             carry
);

  logic [ACC_W:0] sum;

  assign sum = {1'b0, acc} + {1'b0, in_data} + (ACC_W+1)'(cin);

  // Accumulate modulo 2^ACC_W; the bit that overflows is the stage carry.
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      acc   <= '0;
      carry <= 1'b0;
    end else if (clear) begin
      acc   <= '0;
      carry <= 1'b0;
    end else if (enable) begin
      {carry, acc} <= sum;
    end
  end

endmodule

// File: rtl/mash_dsm_param.sv
// rtl/mash_dsm_param.sv - parametrised MASH 1-1-..-1 delta-sigma modulator top
module mash_dsm_param
  import dsm_pkg::*;
#(
  parameter int ACC_W     = 24,
  parameter int MAX_ORDER = 4,
  parameter int OUT_W     = 5,
  parameter int LFSR_W    = 23
) (
  input  logic                    Clk,
  input  logic                    reset,
  input  logic [ACC_W-1:0]        In_Data,
  input  logic                    In_Load,
  input  logic [2:0]              Order,
  input  logic                    Dither_En,
  input  logic                    Enable,
  output logic signed [OUT_W-1:0] Out_Data,
  output logic                    Out_Valid
);

  localparam int LFSR_TAP = lfsr_tap(LFSR_W);

  if (OUT_W < out_w_min(MAX_ORDER)) begin : g_bad_out_w
    $error("mash_dsm_param: OUT_W too narrow for MAX_ORDER");
  end

  logic [ACC_W-1:0]        frac_q;
  logic [2:0]              order_q;
  logic                    dith_q;
  logic [2:0]              order_in;
  logic                    restart;
  logic [LFSR_W-1:0]       lfsr;
  logic [ACC_W-1:0]        acc_q [MAX_ORDER];
  logic [MAX_ORDER-1:0]    carry_q;
  logic signed [OUT_W-1:0] n_cur [MAX_ORDER];
  logic signed [OUT_W-1:0] d_q   [MAX_ORDER];
  logic signed [OUT_W-1:0] n_sum;
  logic signed [OUT_W-1:0] d_above;
  warm_state_e             state;
  warm_state_e             state_next;
  logic                    valid_next;

  assign order_in = clamp_order(Order, MAX_ORDER);
  // Changing the order mid-stream would mix noise transfer functions, so it restarts cleanly.
  assign restart  = In_Load && (order_in != order_q);

  // Shadow registers: loaded on strobe regardless of Enable.
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      frac_q  <= '0;
      order_q <= 3'(MAX_ORDER);
      dith_q  <= 1'b0;
    end else if (In_Load) begin
      frac_q  <= In_Data;
      order_q <= order_in;
      dith_q  <= Dither_En;
    end
  end

  // Dither source: Fibonacci LFSR, seeded all-ones so it never locks at zero.
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      lfsr <= '1;
    end else if (Enable) begin
      lfsr <= {lfsr[LFSR_W-2:0], lfsr[LFSR_W-1] ^ lfsr[LFSR_TAP-1]};
    end
  end

  for (genvar i = 0; i < MAX_ORDER; i++) begin : g_stage
    logic [ACC_W-1:0] stage_in;
    logic             stage_cin;
    logic             stage_clear;

    if (i == 0) begin : g_first
      assign stage_in  = frac_q;
      assign stage_cin = dith_q & lfsr[0];
    end else begin : g_chain
      assign stage_in  = acc_q[i-1];
      assign stage_cin = 1'b0;
    end

    // Stages above the active order stay parked at zero.
    assign stage_clear = restart || (i >= int'(order_q));

    mash_accum #(
      .ACC_W(ACC_W)
    ) u_accum (
      .Clk    (Clk),
      .reset  (reset),
      .enable (Enable),
      .clear  (stage_clear),
      .in_data(stage_in),
      .cin    (stage_cin),
      .acc    (acc_q[i]),
      .carry  (carry_q[i])
    );
  end

  // Recombine top-down: n_i = c_i + n_(i+1) - d_(i+1); parked stages contribute zero.
  always_comb begin
    n_sum   = '0;
    d_above = '0;
    for (int i = MAX_ORDER - 1; i >= 0; i--) begin
      n_sum    = $signed({{(OUT_W-1){1'b0}}, carry_q[i]}) + n_sum - d_above;
      n_cur[i] = n_sum;
      d_above  = d_q[i];
    end
  end

  // One-enabled-cycle delay of each stage's n for the (1 - z^-1) difference.
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      d_q <= '{default: '0};
    end else if (restart) begin
      d_q <= '{default: '0};
    end else if (Enable) begin
      d_q <= n_cur;
    end
  end

  // Warm-up state register.
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Warm-up next state: live once two enabled edges have primed the pipeline.
  always_comb begin
    state_next = state;
    valid_next = 1'b0;
    if (restart) begin
      state_next = ST_IDLE;
    end else if (Enable) begin
      case (state)
        ST_IDLE: state_next = ST_WARM;
        ST_WARM: state_next = ST_LIVE;
        default: state_next = ST_LIVE;
      endcase
      valid_next = (state_next == ST_LIVE);
    end
  end

  // Registered modulus offset and its valid flag.
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      Out_Data  <= '0;
      Out_Valid <= 1'b0;
    end else begin
      Out_Valid <= valid_next;
      if (restart) begin
        Out_Data <= '0;
      end else if (Enable) begin
        Out_Data <= n_cur[0];
      end
    end
  end

endmodule

// File: tb/tb_mash_dsm_param.sv
// tb/tb_mash_dsm_param.sv - self-checking bench for mash_dsm_param
module tb_mash_dsm_param;

  localparam int ACC_W     = 8;
  localparam int MAX_ORDER = 4;
  localparam int OUT_W     = 5;
  localparam int LFSR_W    = 23;
  localparam int MOD       = 1 << ACC_W;
  localparam int NREF      = 4200;

  logic                    Clk = 1'b0;
  logic                    reset = 1'b0;
  logic [ACC_W-1:0]        In_Data = '0;
  logic                    In_Load = 1'b0;
  logic [2:0]              Order = 3'd0;
  logic                    Dither_En = 1'b0;
  logic                    Enable = 1'b0;
  logic signed [OUT_W-1:0] Out_Data;
  logic                    Out_Valid;

  int vectors = 0;
  int miscompares = 0;
  int ref_y [0:NREF];
  int ref_c [1:4][0:NREF];

  always #5 Clk = ~Clk;

  mash_dsm_param #(
    .ACC_W    (ACC_W),
    .MAX_ORDER(MAX_ORDER),
    .OUT_W    (OUT_W),
    .LFSR_W   (LFSR_W)
  ) dut (
    .Clk      (Clk),
    .reset    (reset),
    .In_Data  (In_Data),
    .In_Load  (In_Load),
    .Order    (Order),
    .Dither_En(Dither_En),
    .Enable   (Enable),
    .Out_Data (Out_Data),
    .Out_Valid(Out_Valid)
  );

  task automatic check(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic load(input int frac, input int ord, input bit dith);
    In_Data   = ACC_W'(frac);
    Order     = 3'(ord);
    Dither_En = dith;
    In_Load   = 1'b1;
    step();
    In_Load   = 1'b0;
  endtask

  function automatic int binom(input int n, input int k);
    int r;
    r = 1;
    for (int j = 0; j < k; j++) r = r * (n - j) / (j + 1);
    return r;
  endfunction

  // Fresh-start MASH reference: carries from plain accumulators, output as the
  // binomial FIR y(t) = sum_i sum_j (-1)^j C(i-1,j) c_i(t-j).
  task automatic build_ref(input int frac, input int ord, input int n);
    int acc [1:4];
    int nxt [1:4];
    int s;
    int y;
    for (int i = 1; i <= 4; i++) begin
      acc[i] = 0;
      ref_c[i][0] = 0;
    end
    ref_y[0] = 0;
    for (int t = 1; t <= n; t++) begin
      for (int i = 1; i <= 4; i++) begin
        if (i > ord) s = 0;
        else s = acc[i] + ((i == 1) ? frac : acc[i-1]);
        nxt[i] = s % MOD;
        ref_c[i][t] = s / MOD;
      end
      for (int i = 1; i <= 4; i++) acc[i] = nxt[i];
      y = 0;
      for (int i = 1; i <= ord; i++)
        for (int j = 0; j < i; j++)
          if (t - j >= 0) y += ((j % 2) ? -1 : 1) * binom(i - 1, j) * ref_c[i][t-j];
      ref_y[t] = y;
    end
  endtask

  initial begin
    int  f1, f2, f3, sum, win, o, last;
    bit  found;

    repeat (3) step();
    check("rst_data", int'(Out_Data), 0);
    check("rst_valid", int'(Out_Valid), 0);
    reset = 1'b1;
    step();

    // Order 1, half-scale word: 0,1,0,1,...
    Enable = 1'b1;
    load(MOD / 2, 1, 1'b0);
    check("o1_load_valid", int'(Out_Valid), 0);
    step();
    check("o1_warm_valid", int'(Out_Valid), 0);
    check("o1_warm_data", int'(Out_Data), 0);
    build_ref(MOD / 2, 1, 16);
    for (int m = 0; m < 16; m++) begin
      step();
      check("o1_valid", int'(Out_Valid), 1);
      check("o1_alt", int'(Out_Data), m % 2);
      check("o1_model", int'(Out_Data), ref_y[m+1]);
    end

    // Order 3, quarter-scale word: range, window sums, sample-exact model.
    load(MOD / 4, 3, 1'b0);
    check("o3_load_valid", int'(Out_Valid), 0);
    step();
    check("o3_warm_valid", int'(Out_Valid), 0);
    build_ref(MOD / 4, 3, 4096);
    win = 0;
    for (int m = 0; m < 4096; m++) begin
      step();
      o = int'(Out_Data);
      check("o3_valid", int'(Out_Valid), 1);
      check("o3_range", int'(o >= -3 && o <= 4), 1);
      check("o3_model", o, ref_y[m+1]);
      win += o;
      if (m % MOD == MOD - 1) begin
        if (m >= MOD) check("o3_window", win, MOD / 4);
        win = 0;
      end
    end

    // Order 4, zero word, no dither: silence.
    load(0, 4, 1'b0);
    step();
    for (int m = 0; m < 64; m++) begin
      step();
      check("o4_zero_valid", int'(Out_Valid), 1);
      check("o4_zero_data", int'(Out_Data), 0);
    end

    // Same with dither: bounded samples, mean near zero.
    load(0, 4, 1'b1);
    sum = 0;
    for (int m = 0; m < 65536; m++) begin
      step();
      o = int'(Out_Data);
      check("o4_dith_range", int'(o >= -7 && o <= 8), 1);
      sum += o;
    end
    check("o4_dith_valid", int'(Out_Valid), 1);
    check("o4_dith_mean", int'(((sum < 0) ? -sum : sum) * MOD <= 16 * 65536), 1);

    // Order 3 with a random word, then a live switch to order 2.
    f1 = int'($urandom_range(1, MOD - 1));
    load(f1, 3, 1'b0);
    check("oc3_load_valid", int'(Out_Valid), 0);
    step();
    check("oc3_warm_valid", int'(Out_Valid), 0);
    build_ref(f1, 3, 100);
    for (int m = 0; m < 100; m++) begin
      step();
      check("oc3_valid", int'(Out_Valid), 1);
      check("oc3_model", int'(Out_Data), ref_y[m+1]);
    end
    f2 = int'($urandom_range(1, MOD - 1));
    load(f2, 2, 1'b0);
    check("oc2_load_valid", int'(Out_Valid), 0);
    step();
    check("oc2_warm_valid", int'(Out_Valid), 0);
    check("oc2_warm_data", int'(Out_Data), 0);
    build_ref(f2, 2, 200);
    for (int m = 0; m < 60; m++) begin
      step();
      check("oc2_valid", int'(Out_Valid), 1);
      check("oc2_model", int'(Out_Data), ref_y[m+1]);
    end

    // Enable gap: output frozen, then resumes where it stopped.
    last   = ref_y[60];
    Enable = 1'b0;
    for (int g = 0; g < 10; g++) begin
      step();
      check("gap_valid", int'(Out_Valid), 0);
      check("gap_hold", int'(Out_Data), last);
    end
    Enable = 1'b1;
    for (int m = 60; m < 140; m++) begin
      step();
      check("resume_valid", int'(Out_Valid), 1);
      check("resume_model", int'(Out_Data), ref_y[m+1]);
    end

    // Asynchronous reset mid-cycle while the output is nonzero.
    found = 1'b0;
    for (int w = 0; w < 50 && !found; w++) begin
      if (int'(Out_Data) != 0) found = 1'b1;
      else step();
    end
    check("arst_pre_nonzero", int'(found), 1);
    #2;
    reset = 1'b0;
    #1;
    check("arst_data", int'(Out_Data), 0);
    check("arst_valid", int'(Out_Valid), 0);
    repeat (2) step();
    reset = 1'b1;
    step();
    check("post_warm_valid", int'(Out_Valid), 0);
    step();
    check("post_live_valid", int'(Out_Valid), 1);
    check("post_live_data", int'(Out_Data), 0);

    // Loading the maximum order must not restart: shadow order came back at MAX_ORDER.
    f3 = int'($urandom_range(1, MOD - 1));
    load(f3, MAX_ORDER, 1'b0);
    check("post_load_valid", int'(Out_Valid), 1);
    check("post_load_data", int'(Out_Data), 0);
    build_ref(f3, MAX_ORDER, 100);
    for (int m = 0; m < 100; m++) begin
      step();
      check("post_valid", int'(Out_Valid), 1);
      check("post_model", int'(Out_Data), ref_y[m]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
